// File: rtl/full_adder_pkg.sv
// Shared constants, result payload type and overflow equation for the full_adder datapath cell.
package full_adder_pkg;

    localparam int unsigned FA_MAX_WIDTH = 64;

    // Widest possible add result; narrower instances use the low sum bits.
    typedef struct packed {
        logic                    carry;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

    // Signed overflow: carry out of the MSB disagrees with carry into it.
    function automatic logic fa_overflow(input logic carry_out, input logic carry_msb_in);
        return carry_out ^ carry_msb_in;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit combinational full adder cell used to build the ripple chain.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry add-with-carry; result appears one clock after a valid sample.
// Optional signed overflow output is built when FULL_ADDER_OVERFLOW_EN is defined.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Each stage keeps its own carry so the chain has no self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g_bit[i-1].co;
        end
        fa_bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .sum  (sum_c[i]),
            .cout (co)
        );
    end

    assign cout_c = g_bit[WIDTH-1].co;

`ifdef FULL_ADDER_OVERFLOW_EN
    logic carry_msb_in_c;
    logic overflow_c;

    if (WIDTH == 1) begin : g_msb_w1
        assign carry_msb_in_c = cin;
    end else begin : g_msb_wn
        assign carry_msb_in_c = g_bit[WIDTH-2].co;
    end

    assign overflow_c = fa_overflow(cout_c, carry_msb_in_c);
`endif

    // Result register: loads only on valid input, so idle operands never disturb held values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_c;
                cout     <= cout_c;
`ifdef FULL_ADDER_OVERFLOW_EN
                overflow <= overflow_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder at WIDTH=1 and WIDTH=8 (overflow checks when FULL_ADDER_OVERFLOW_EN is defined).
module tb_full_adder;

    logic       clk;
    logic       rst;

    logic       a1, b1, cin1, v1;
    logic       sum1, cout1, ov1;

    logic [7:0] a8, b8;
    logic       cin8, v8;
    logic [7:0] sum8;
    logic       cout8, ov8;

`ifdef FULL_ADDER_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    int tests  = 0;
    int errors = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .in_valid  (v1),
        .sum       (sum1),
        .cout      (cout1),
        .out_valid (ov1)
`ifdef FULL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ovf1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .in_valid  (v8),
        .sum       (sum8),
        .cout      (cout8),
        .out_valid (ov8)
`ifdef FULL_ADDER_OVERFLOW_EN
        ,
        .overflow  (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle outputs before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic c, input logic v);
        check({tag, ".sum"},   64'(sum8),  64'(s));
        check({tag, ".cout"},  64'(cout8), 64'(c));
        check({tag, ".valid"}, 64'(ov8),   64'(v));
    endtask

    task automatic check1(input string tag, input logic s, input logic c, input logic v);
        check({tag, ".sum"},   64'(sum1),  64'(s));
        check({tag, ".cout"},  64'(cout1), 64'(c));
        check({tag, ".valid"}, 64'(ov1),   64'(v));
    endtask

    logic [1:0] exp_w1 [8];
    logic [2:0] vec;

    initial begin
        exp_w1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; v8 = 1'b1;
        step();
        step();
        check1("rst_w1", 1'b0, 1'b0, 1'b0);
        check8("rst_w8", 8'h00, 1'b0, 1'b0);
        v8 = 1'b0;

        // Release with 1+1+1 still applied: first result one cycle later.
        rst = 1'b0;
        step();
        check1("rst_release_w1", 1'b1, 1'b1, 1'b1);
        check("rst_release_w8.valid", 64'(ov8), 64'd0);

        for (int k = 0; k < 8; k++) begin
            vec = 3'(k);
            {a1, b1, cin1} = vec;
            v1 = 1'b1;
            step();
            check($sformatf("exh_w1_%0d.cout_sum", k), 64'({cout1, sum1}), 64'(exp_w1[k]));
            check($sformatf("exh_w1_%0d.valid", k), 64'(ov1), 64'd1);
        end

        // Reset beats in_valid.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1; rst = 1'b1;
        step();
        check1("rst_pri_w1", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check1("rst_pri_rel_w1", 1'b1, 1'b1, 1'b1);

        // Hold across idle cycles, including unknown operands.
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; v1 = 1'b1;
        step();
        check1("hold_load_w1", 1'b0, 1'b1, 1'b1);
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b0;
        step();
        check1("hold_w1", 1'b0, 1'b1, 1'b0);
        a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
        step();
        check1("hold_x_w1", 1'b0, 1'b1, 1'b0);
        v1 = 1'b0;

        // WIDTH=8 back-to-back vectors.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
        step();
        check8("wrap_w8", 8'h00, 1'b1, 1'b1);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
        step();
        check8("cin_only_w8", 8'h01, 1'b0, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        step();
        check8("full_carry_w8", 8'hFF, 1'b1, 1'b1);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        step();
        check8("pos_ovf_w8", 8'h80, 1'b0, 1'b1);
`ifdef FULL_ADDER_OVERFLOW_EN
        check("pos_ovf_w8.overflow", 64'(ovf8), 64'd1);
`endif
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        step();
        check8("neg_ovf_w8", 8'h00, 1'b1, 1'b1);
`ifdef FULL_ADDER_OVERFLOW_EN
        check("neg_ovf_w8.overflow", 64'(ovf8), 64'd1);
`endif
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        step();
        check8("no_ovf_w8", 8'h02, 1'b0, 1'b1);
`ifdef FULL_ADDER_OVERFLOW_EN
        check("no_ovf_w8.overflow", 64'(ovf8), 64'd0);
`endif

        // Mid-stream reset discards the in-flight sample.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; rst = 1'b1;
        step();
        check8("mid_rst_w8", 8'h00, 1'b0, 1'b0);
        rst = 1'b0; v8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        step();
        check8("post_rst_idle_w8", 8'h00, 1'b0, 1'b0);
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; v8 = 1'b1;
        step();
        check8("post_rst_w8", 8'h00, 1'b1, 1'b1);
        v8 = 1'b0;
        step();
        check8("post_rst_hold_w8", 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
